// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive path.
//   pair_state_t     : left/right pairing FSM states
//   CHNL_LEFT/RIGHT  : encoding of the lr_chnl strobe qualifier
//   I2S_WORD_WIDTH   : default bits per channel word
//   sat_inc8()       : 8-bit saturating increment
package i2s_pkg;

  typedef enum logic {
    WAIT_L = 1'b0,
    WAIT_R = 1'b1
  } pair_state_t;

  localparam logic CHNL_LEFT  = 1'b0;
  localparam logic CHNL_RIGHT = 1'b1;

  localparam int unsigned I2S_WORD_WIDTH = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2s_sync_fifo.sv
// First-word fall-through synchronous FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and write data
//   pop_i         : read request (ignored when empty)
//   data_o        : head entry, 0 while empty
//   full_o/empty_o: status flags
//   level_o       : entries stored, 0 .. 2**DEPTH_LOG2
// A push while full is accepted when a pop happens in the same cycle.
module i2s_sync_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (level_q == LVL_FULL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/i2s_rx_frame_buffer.sv
// Pairs left/right I2S words into stereo frames and buffers them.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   data_i, lr_chnl_i   : received word and its channel (0 left, 1 right)
//   write_i             : strobe qualifying data_i/lr_chnl_i
//   frame_o, valid_o    : head frame {left,right}, FIFO not empty
//   ready_i             : consumer accepts head when valid_o && ready_i
//   level_o             : frames stored
//   drop_o, overflow_o  : one-cycle pulses for orphan word / lost frame
//   drop_cnt_o          : saturating count of those pulses
module i2s_rx_frame_buffer
  import i2s_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = I2S_WORD_WIDTH,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [WORD_WIDTH-1:0]   data_i,
  input  logic                    lr_chnl_i,
  input  logic                    write_i,
  output logic [2*WORD_WIDTH-1:0] frame_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [DEPTH_LOG2:0]     level_o,
  output logic                    drop_o,
  output logic                    overflow_o,
  output logic [7:0]              drop_cnt_o
);

  pair_state_t           state_q, state_d;
  logic [WORD_WIDTH-1:0] left_q, left_d;
  logic                  drop_q, drop_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            cnt_q, cnt_d;

  logic push_req, fifo_full, fifo_empty, pop;

  assign valid_o    = !fifo_empty;
  assign pop        = valid_o && ready_i;
  assign drop_o     = drop_q;
  assign overflow_o = ovf_q;
  assign drop_cnt_o = cnt_q;

  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    drop_d   = 1'b0;
    push_req = 1'b0;
    if (write_i) begin
      unique case (state_q)
        WAIT_L: begin
          if (lr_chnl_i == CHNL_LEFT) begin
            left_d  = data_i;
            state_d = WAIT_R;
          end else begin
            drop_d = 1'b1;
          end
        end
        WAIT_R: begin
          if (lr_chnl_i == CHNL_RIGHT) begin
            push_req = 1'b1;
            state_d  = WAIT_L;
          end else begin
            // Newer left word replaces the orphaned one.
            drop_d = 1'b1;
            left_d = data_i;
          end
        end
        default: state_d = WAIT_L;
      endcase
    end
    // Mirrors the FIFO acceptance rule: full is only fatal without a pop.
    ovf_d = push_req && fifo_full && !pop;
    // Counter follows the registered pulses, one per pulse cycle.
    cnt_d = (drop_q || ovf_q) ? sat_inc8(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAIT_L;
      left_q  <= '0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  i2s_sync_fifo #(
    .WIDTH      (2*WORD_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_req),
    .data_i  ({left_q, data_i}),
    .pop_i   (pop),
    .data_o  (frame_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

endmodule

// File: tb/tb_i2s_rx_frame_buffer.sv
module tb_i2s_rx_frame_buffer;

  localparam int WW    = 16;
  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [WW-1:0]   data = '0;
  logic            lr = 1'b0;
  logic            wr = 1'b0;
  logic            rdy = 1'b0;
  logic [2*WW-1:0] frame_o;
  logic            valid_o;
  logic [DL:0]     level_o;
  logic            drop_o;
  logic            overflow_o;
  logic [7:0]      drop_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  int n_ovf_seen = 0;

  always #5 clk = ~clk;

  i2s_rx_frame_buffer #(
    .WORD_WIDTH (WW),
    .DEPTH_LOG2 (DL)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .data_i     (data),
    .lr_chnl_i  (lr),
    .write_i    (wr),
    .frame_o    (frame_o),
    .valid_o    (valid_o),
    .ready_i    (rdy),
    .level_o    (level_o),
    .drop_o     (drop_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of frames plus "holding a left word" flag.
  logic [2*WW-1:0] mq[$];
  bit              m_have = 0;
  logic [WW-1:0]   m_left = '0;
  bit              m_drop = 0;
  bit              m_ovf = 0;
  int              m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    bit pop, push, nd, no;
    logic [2*WW-1:0] f;
    if (!rst_n) begin
      mq.delete();
      m_have = 0;
      m_left = '0;
      m_drop = 0;
      m_ovf  = 0;
      m_cnt  = 0;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      push = 0;
      nd   = 0;
      no   = 0;
      f    = '0;
      if (m_drop || m_ovf) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      if (wr) begin
        if (lr == 1'b0) begin
          if (m_have) nd = 1;
          m_have = 1;
          m_left = data;
        end else if (!m_have) begin
          nd = 1;
        end else begin
          f = {m_left, data};
          m_have = 0;
          if (mq.size() < DEPTH || pop) push = 1;
          else no = 1;
        end
      end
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(f);
      m_drop = nd;
      m_ovf  = no;
    end
  end

  // Single compare process against the model, every cycle.
  always @(negedge clk) begin
    chk("valid", 64'(valid_o), 64'(mq.size() != 0));
    chk("level", 64'(level_o), 64'(mq.size()));
    chk("drop", 64'(drop_o), 64'(m_drop));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt_o), 64'(m_cnt));
    if (mq.size() != 0) chk("frame", 64'(frame_o), 64'(mq[0]));
    if (overflow_o === 1'b1) n_ovf_seen++;
  end

  task automatic tick(input bit w, input bit l, input logic [WW-1:0] d, input bit r);
    wr = w; lr = l; data = d; rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick(0, 0, '0, 0);
    rst_n = 1'b1;
    tick(0, 0, '0, 0);
  endtask

  function automatic logic [2*WW-1:0] mkf(input int i);
    logic [WW-1:0] l, r;
    l = WW'(i);
    r = WW'(16'h0100 + i);
    return {l, r};
  endfunction

  initial begin
    logic [2*WW-1:0] exp_f;

    // Reset values
    rst_n = 1'b0;
    tick(0, 0, '0, 0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_frame", 64'(frame_o), 64'd0);
    chk("rst_drop", 64'(drop_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_cnt", 64'(drop_cnt_o), 64'd0);
    do_reset();

    // Normal pairing
    tick(1, 0, 16'h1234, 0);
    tick(1, 1, 16'hABCD, 0);
    tick(1, 0, 16'h0001, 0);
    tick(1, 1, 16'h0002, 0);
    chk("pair_level", 64'(level_o), 64'd2);
    chk("pair_frame0", 64'(frame_o), 64'h1234ABCD);
    chk("pair_model0", 64'(mq[0]), 64'h1234ABCD);
    tick(0, 0, '0, 1);
    chk("pair_frame1", 64'(frame_o), 64'h00010002);
    chk("pair_level1", 64'(level_o), 64'd1);
    tick(0, 0, '0, 1);
    tick(0, 0, '0, 1);
    chk("pair_empty_pop", 64'(level_o), 64'd0);

    // Orphan handling
    do_reset();
    tick(1, 1, 16'h5555, 0);
    chk("orph_drop1", 64'(drop_o), 64'd1);
    tick(1, 0, 16'h1111, 0);
    tick(1, 0, 16'h2222, 0);
    chk("orph_drop2", 64'(drop_o), 64'd1);
    tick(1, 1, 16'h3333, 0);
    chk("orph_cnt", 64'(drop_cnt_o), 64'd2);
    chk("orph_level", 64'(level_o), 64'd1);
    chk("orph_frame", 64'(frame_o), 64'h22223333);

    // Overflow: 9 frames into depth 8
    do_reset();
    n_ovf_seen = 0;
    for (int i = 1; i <= 9; i++) begin
      tick(1, 0, WW'(i), 0);
      tick(1, 1, WW'(16'h0100 + i), 0);
    end
    tick(0, 0, '0, 0);
    chk("ovf_level", 64'(level_o), 64'd8);
    chk("ovf_pulses", 64'(n_ovf_seen), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      exp_f = mkf(i);
      chk("ovf_order", 64'(frame_o), 64'(exp_f));
      tick(0, 0, '0, 1);
    end
    chk("ovf_drained", 64'(valid_o), 64'd0);

    // Full push with simultaneous pop
    do_reset();
    n_ovf_seen = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1, 0, WW'(i), 0);
      tick(1, 1, WW'(16'h0100 + i), 0);
    end
    tick(1, 0, WW'(9), 0);
    tick(1, 1, WW'(16'h0109), 1);
    chk("fp_ovf", 64'(overflow_o), 64'd0);
    chk("fp_level", 64'(level_o), 64'd8);
    for (int i = 2; i <= 9; i++) begin
      exp_f = mkf(i);
      chk("fp_order", 64'(frame_o), 64'(exp_f));
      tick(0, 0, '0, 1);
    end
    chk("fp_pulses", 64'(n_ovf_seen), 64'd0);

    // Reset mid-frame
    tick(1, 0, 16'hAAAA, 0);
    rst_n = 1'b0;
    repeat (3) tick(0, 0, '0, 0);
    rst_n = 1'b1;
    tick(1, 1, 16'hBBBB, 0);
    chk("mid_drop", 64'(drop_o), 64'd1);
    chk("mid_level", 64'(level_o), 64'd0);
    chk("mid_valid", 64'(valid_o), 64'd0);

    // Counter saturation
    do_reset();
    repeat (300) tick(1, 1, WW'($urandom), 0);
    tick(0, 0, '0, 0);
    tick(0, 0, '0, 0);
    chk("sat_cnt", 64'(drop_cnt_o), 64'd255);
    repeat (5) tick(1, 1, '0, 0);
    tick(0, 0, '0, 0);
    tick(0, 0, '0, 0);
    chk("sat_hold", 64'(drop_cnt_o), 64'd255);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 5) >= 3),
           WW'($urandom), bit'($urandom_range(0, 2) == 0));
      if ((n % 700) == 699) do_reset();
    end
    tick(0, 0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_rx_frame_buffer.md
# i2s_rx_frame_buffer

Downstream stage of `i2s_top_rx`, clocked from the same `clk_i`. Takes the per-word strobe stream (`data_o`, `lr_chnl_o`, `write_o`) and pairs each left word with the following right word into one stereo frame. Frames are buffered in a small synchronous FIFO and delivered to the consumer over a valid/ready handshake. Channel-order errors and FIFO overflows are flagged rather than silently corrupting frame alignment.

## Interface
- `WORD_WIDTH`, 16, bits per channel word; must match `i2s_top_rx.WORD_WIDTH`.
- `DEPTH_LOG2`, 3, log2 of FIFO depth in frames (depth 8 by default).
- `clk_i`  in  1  system clock; same domain as `i2s_top_rx`.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `data_i`  in  WORD_WIDTH  received word; connects to `i2s_top_rx.data_o`.
- `lr_chnl_i`  in  1  channel of `data_i`: 0 = left, 1 = right.
- `write_i`  in  1  single-cycle strobe; `data_i`/`lr_chnl_i` are valid when high.
- `frame_o`  out  2*WORD_WIDTH  head frame, packed as {left, right}; left in the MSBs.
- `valid_o`  out  1  FIFO not empty; `frame_o` is valid.
- `ready_i`  in  1  consumer accepts `frame_o` when `valid_o && ready_i`.
- `level_o`  out  DEPTH_LOG2+1  number of frames stored.
- `drop_o`  out  1  one-cycle pulse: an orphan word was discarded.
- `overflow_o`  out  1  one-cycle pulse: a complete frame was discarded because the FIFO was full.
- `drop_cnt_o`  out  8  saturating count of `drop_o` pulses plus `overflow_o` pulses; saturates at 255.

## Operation
- Pairing FSM, states `WAIT_L` and `WAIT_R`; reset state is `WAIT_L`. Inputs are evaluated only when `write_i` = 1.
- In `WAIT_L`:
  - left word: capture it into `left_q`; go to `WAIT_R`.
  - right word: pulse `drop_o`; stay in `WAIT_L`.
- In `WAIT_R`:
  - right word: build frame {`left_q`, `data_i`}, request a push, go to `WAIT_L`.
  - left word: pulse `drop_o`, overwrite `left_q` with the new word, stay in `WAIT_R`. The newest left word is the one kept.
- Push rules:
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle. In the second case `level_o` is unchanged.
  - Otherwise the frame is discarded, `overflow_o` pulses, and the FSM still returns to `WAIT_L`.
- Pop: occurs when `valid_o && ready_i`. The FIFO is first-word fall-through, so `frame_o` always shows the oldest entry.
- Pointers are DEPTH_LOG2 bits and wrap modulo the depth. `level_o` is maintained separately, from 0 to 2^DEPTH_LOG2.
- `drop_cnt_o` increments by 1 per cycle in which `drop_o` or `overflow_o` is high. The two cannot occur in the same cycle. The counter holds at 255.
- `ready_i` with an empty FIFO has no effect.

## Timing
- Reset (asynchronous assert, synchronous release) gives:
  - `valid_o`=0, `level_o`=0, `drop_o`=0, `overflow_o`=0, `drop_cnt_o`=0.
  - `frame_o`=0, `left_q`=0, FSM in `WAIT_L`, both pointers at 0.
- Reset asserted mid-frame discards any captured left word and empties the FIFO. The first word accepted after reset must be a left word.
- Latency: a right-word strobe sampled at edge N raises `valid_o` after edge N, with the matching frame on `frame_o` in the same cycle.
- A pop at edge N advances `frame_o` and updates `level_o` after edge N.
- `drop_o` and `overflow_o` are registered. Each is high for exactly the one cycle following the edge at which its event was sampled.
- Back-to-back `write_i` on consecutive cycles is supported at full rate.

## Structure
- Shared package `i2s_pkg` holds:
  - the FSM state encoding `pair_state_t` (`WAIT_L`=0, `WAIT_R`=1);
  - the channel constants `CHNL_LEFT`=0 and `CHNL_RIGHT`=1;
  - the default `WORD_WIDTH`.
- One sub-module, `i2s_sync_fifo` (parameters `WIDTH`, `DEPTH_LOG2`):
  - a first-word fall-through FIFO;
  - push, pop, full, empty, and level signals;
  - full-and-pop-same-cycle push acceptance as specified above.
- The pairing FSM, `left_q`, and the error counter live in `i2s_rx_frame_buffer`.

## Test plan
- Normal pairing:
  - Stimulus: L=0x1234, R=0xABCD, then L=0x0001, R=0x0002, with `ready_i`=0.
  - Required: `level_o`=2, `frame_o`=0x1234ABCD; after one pop, `frame_o`=0x00010002.
- Orphan handling:
  - Stimulus: R=0x5555 first, then L=0x1111, L=0x2222, R=0x3333.
  - Required: two `drop_o` pulses, `drop_cnt_o`=2, exactly one frame 0x22223333 stored.
- Overflow:
  - Stimulus: 9 complete frames with `ready_i`=0 and `DEPTH_LOG2`=3.
  - Required: `level_o`=8, one `overflow_o` pulse, and frames 1–8 pop out in order.
- Full push with simultaneous pop:
  - Stimulus: fill to 8, then hold `ready_i`=1 during the cycle the 9th right strobe is sampled.
  - Required: no `overflow_o`, `level_o` stays 8, and frame 9 is output last.
- Reset mid-frame:
  - Stimulus: L=0xAAAA, then `rst_ni` low for 3 cycles, then R=0xBBBB.
  - Required: `drop_o` pulses, `level_o`=0, `valid_o`=0.
- Counter saturation:
  - Stimulus: 300 orphan right words.
  - Required: `drop_cnt_o`=255 and it holds there.
